// File: rtl/gpr_wr_arbiter_pkg.sv
// Shared widths, constants and arbitration state encoding for the GPR write-port arbiter.
package gpr_wr_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_NUM    = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
  localparam logic                  WRITE_EN  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for long-latency results, with three busy lookups for ID.
module gpr_scoreboard #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_wa_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_wa_i,
  input  logic [ADDR_W-1:0] rs1_ra_i,
  input  logic [ADDR_W-1:0] rs2_ra_i,
  input  logic [ADDR_W-1:0] wa_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              wa_busy_o
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Set is applied after clear so an issue to the retiring register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_wa_i] = 1'b0;
    if (set_i && (set_wa_i != '0)) pend_d[set_wa_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // A register retiring this cycle is forwarded by the register file, so it is not busy.
  function automatic logic busy(input logic [ADDR_W-1:0] a);
    return (a != '0) && pend_q[a] && !(clr_i && (clr_wa_i == a));
  endfunction

  assign rs1_busy_o = busy(rs1_ra_i);
  assign rs2_busy_o = busy(rs2_ra_i);
  assign wa_busy_o  = busy(wa_i);

endmodule

// File: rtl/gpr_wr_arbiter.sv
// Arbitrates the single GPR write port between the WB stage and a long-latency unit,
// forcing a one-cycle pipeline hold when the long-latency result starves.
import gpr_wr_arbiter_pkg::*;

module gpr_wr_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p_we_i,
  input  logic [ADDR_W-1:0] p_wa_i,
  input  logic [DATA_W-1:0] p_wd_i,
  output logic              p_hold_o,
  input  logic              m_valid_i,
  input  logic [ADDR_W-1:0] m_wa_i,
  input  logic [DATA_W-1:0] m_wd_i,
  output logic              m_ready_o,
  input  logic              sb_set_i,
  input  logic [ADDR_W-1:0] sb_wa_i,
  input  logic              id_rs1_re_i,
  input  logic              id_rs2_re_i,
  input  logic [ADDR_W-1:0] id_rs1_ra_i,
  input  logic [ADDR_W-1:0] id_rs2_ra_i,
  input  logic              id_we_i,
  input  logic [ADDR_W-1:0] id_wa_i,
  output logic              stall_o,
  output logic              rd_we_o,
  output logic [ADDR_W-1:0] rd_wa_o,
  output logic [DATA_W-1:0] rd_wd_o
);

  localparam logic [WAIT_CNT_W-1:0] FORCE_AT = WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic p_req, m_req, m_lose;
  logic grant_p, grant_m, m_ready, p_hold;
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic rs1_busy, rs2_busy, wa_busy, stall;

  assign p_req = p_we_i && (p_wa_i != '0);
  assign m_req = m_valid_i;

  always_comb begin
    grant_p    = 1'b0;
    grant_m    = 1'b0;
    m_ready    = 1'b0;
    p_hold     = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;

    if (state_q == ARB_FORCE) begin
      p_hold  = 1'b1;
      m_ready = 1'b1;
      grant_m = m_req;
    end else if (p_req) begin
      grant_p = 1'b1;
    end else if (m_req) begin
      grant_m = 1'b1;
      m_ready = 1'b1;
    end

    m_lose = m_req && !grant_m;

    if (!m_req || grant_m) wait_cnt_d = '0;
    else                   wait_cnt_d = wait_cnt_q + 1'b1;

    // IDLE always holds wait_cnt=0, so sharing the FORCE check lets MAX_WAIT=1 work too.
    unique case (state_q)
      ARB_IDLE, ARB_WAIT: begin
        if (m_lose) state_d = (wait_cnt_q == FORCE_AT) ? ARB_FORCE : ARB_WAIT;
        else        state_d = ARB_IDLE;
      end
      ARB_FORCE: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = ZERO_WORD[DATA_W-1:0];
    if (grant_p) begin
      we = WRITE_EN;
      wa = p_wa_i;
      wd = p_wd_i;
    end else if (grant_m) begin
      we = (m_wa_i != '0);
      wa = m_wa_i;
      wd = m_wd_i;
    end
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (sb_set_i),
    .set_wa_i   (sb_wa_i),
    .clr_i      (grant_m),
    .clr_wa_i   (m_wa_i),
    .rs1_ra_i   (id_rs1_ra_i),
    .rs2_ra_i   (id_rs2_ra_i),
    .wa_i       (id_wa_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .wa_busy_o  (wa_busy)
  );

  assign stall = (id_rs1_re_i && rs1_busy) || (id_rs2_re_i && rs2_busy) ||
                 (id_we_i && wa_busy) || p_hold;

  assign m_ready_o = !rst_i && m_ready;
  assign p_hold_o  = !rst_i && p_hold;
  assign stall_o   = !rst_i && stall;
  assign rd_we_o   = !rst_i && we;
  assign rd_wa_o   = rst_i ? '0 : wa;
  assign rd_wd_o   = rst_i ? '0 : wd;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Directed and randomized checks of gpr_wr_arbiter against a loss-count/pending-set model.
module tb_gpr_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst_i;
  logic p_we_i;
  logic [AW-1:0] p_wa_i;
  logic [DW-1:0] p_wd_i;
  logic p_hold_o;
  logic m_valid_i;
  logic [AW-1:0] m_wa_i;
  logic [DW-1:0] m_wd_i;
  logic m_ready_o;
  logic sb_set_i;
  logic [AW-1:0] sb_wa_i;
  logic id_rs1_re_i, id_rs2_re_i;
  logic [AW-1:0] id_rs1_ra_i, id_rs2_ra_i;
  logic id_we_i;
  logic [AW-1:0] id_wa_i;
  logic stall_o;
  logic rd_we_o;
  logic [AW-1:0] rd_wa_o;
  logic [DW-1:0] rd_wd_o;

  always #5 clk = ~clk;

  gpr_wr_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .p_we_i      (p_we_i),
    .p_wa_i      (p_wa_i),
    .p_wd_i      (p_wd_i),
    .p_hold_o    (p_hold_o),
    .m_valid_i   (m_valid_i),
    .m_wa_i      (m_wa_i),
    .m_wd_i      (m_wd_i),
    .m_ready_o   (m_ready_o),
    .sb_set_i    (sb_set_i),
    .sb_wa_i     (sb_wa_i),
    .id_rs1_re_i (id_rs1_re_i),
    .id_rs2_re_i (id_rs2_re_i),
    .id_rs1_ra_i (id_rs1_ra_i),
    .id_rs2_ra_i (id_rs2_ra_i),
    .id_we_i     (id_we_i),
    .id_wa_i     (id_wa_i),
    .stall_o     (stall_o),
    .rd_we_o     (rd_we_o),
    .rd_wa_o     (rd_wa_o),
    .rd_wd_o     (rd_wd_o)
  );

  // Reference model: set of registers owed by M, and count of consecutive lost M cycles.
  bit mp [32];
  int losses;
  bit e_gp, e_gm, e_force, e_hold, e_ready, e_stall, e_we;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [AW-1:0] a);
    return (a != 0) && mp[a] && !(e_gm && m_wa_i == a);
  endfunction

  task automatic model_outputs();
    bit preq;
    preq    = p_we_i && (p_wa_i != 0);
    e_force = m_valid_i && (losses >= MW);
    e_hold  = e_force;
    e_gp    = !e_force && preq;
    e_gm    = e_force || (!preq && m_valid_i);
    e_ready = e_gm;
    e_we    = e_gp || (e_gm && m_wa_i != 0);
    e_wa    = e_gp ? p_wa_i : (e_gm ? m_wa_i : '0);
    e_wd    = e_gp ? p_wd_i : (e_gm ? m_wd_i : '0);
    e_stall = (id_rs1_re_i && busy(id_rs1_ra_i)) || (id_rs2_re_i && busy(id_rs2_ra_i)) ||
              (id_we_i && busy(id_wa_i)) || e_hold;
    if (rst_i) begin
      e_gp = 0; e_gm = 0; e_force = 0; e_hold = 0; e_ready = 0; e_stall = 0;
      e_we = 0; e_wa = '0; e_wd = '0;
    end
  endtask

  task automatic settle();
    #1;
    model_outputs();
    chk("m_ready", 32'(m_ready_o), 32'(e_ready));
    chk("p_hold",  32'(p_hold_o),  32'(e_hold));
    chk("stall",   32'(stall_o),   32'(e_stall));
    chk("rd_we",   32'(rd_we_o),   32'(e_we));
    chk("rd_wa",   32'(rd_wa_o),   32'(e_wa));
    chk("rd_wd",   rd_wd_o,        e_wd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_i) begin
      foreach (mp[i]) mp[i] = 0;
      losses = 0;
    end else begin
      if (e_gm) mp[m_wa_i] = 0;
      if (sb_set_i && sb_wa_i != 0) mp[sb_wa_i] = 1;
      if (e_force || e_gm || !m_valid_i) losses = 0;
      else losses++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p_we_i = 0; p_wa_i = '0; p_wd_i = '0;
    m_valid_i = 0; m_wa_i = '0; m_wd_i = '0;
    sb_set_i = 0; sb_wa_i = '0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; id_rs1_ra_i = '0; id_rs2_ra_i = '0;
    id_we_i = 0; id_wa_i = '0;
  endtask

  logic [DW-1:0] pdat;
  bit p_held;

  initial begin
    foreach (mp[i]) mp[i] = 0;
    losses = 0;
    idle_inputs();
    rst_i = 1;
    p_we_i = 1; p_wa_i = 5'd3; p_wd_i = 32'h1234; m_valid_i = 1; m_wa_i = 5'd4;
    settle();
    tick();
    idle_inputs();
    rst_i = 0;

    // M only, retiring a pending register with a same-cycle read of it
    sb_set_i = 1; sb_wa_i = 5'd5;
    settle(); tick();
    sb_set_i = 0;
    m_valid_i = 1; m_wa_i = 5'd5; m_wd_i = 32'hDEAD;
    id_rs1_re_i = 1; id_rs1_ra_i = 5'd5;
    settle();
    chk("monly_ready", 32'(m_ready_o), 32'd1);
    chk("monly_wd", rd_wd_o, 32'hDEAD);
    chk("monly_stall", 32'(stall_o), 32'd0);
    tick();
    m_valid_i = 0;
    settle(); tick();
    idle_inputs();

    // Contention: P every cycle, M valid from cycle 0
    pdat = 32'h100;
    m_valid_i = 1; m_wa_i = 5'd6; m_wd_i = 32'hBEEF;
    p_we_i = 1; p_wa_i = 5'd3;
    for (int k = 0; k < 6; k++) begin
      p_wd_i = pdat;
      settle();
      if (k < 4) chk("cont_p_granted", 32'(rd_wa_o), 32'd3);
      if (k == 4) begin
        chk("force_hold", 32'(p_hold_o), 32'd1);
        chk("force_stall", 32'(stall_o), 32'd1);
        chk("force_wd", rd_wd_o, 32'hBEEF);
      end
      if (k == 5) chk("held_p_written", rd_wd_o, 32'h104);
      tick();
      if (!e_hold) pdat++;
      if (e_gm) m_valid_i = 0;
    end
    idle_inputs();

    // RAW on a pending register until its M grant
    sb_set_i = 1; sb_wa_i = 5'd7;
    settle(); tick();
    sb_set_i = 0; id_rs1_re_i = 1; id_rs1_ra_i = 5'd7;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("raw_stall", 32'(stall_o), 32'd1);
      tick();
    end
    sb_set_i = 1; sb_wa_i = 5'd7;
    settle(); tick();
    sb_set_i = 0;
    id_rs1_re_i = 0; id_we_i = 1; id_wa_i = 5'd7;
    settle();
    chk("waw_stall", 32'(stall_o), 32'd1);
    tick();
    m_valid_i = 1; m_wa_i = 5'd7; m_wd_i = 32'h77;
    settle();
    chk("grant_no_stall", 32'(stall_o), 32'd0);
    tick();
    idle_inputs();

    // Set and clear of the same register in one cycle: set wins
    sb_set_i = 1; sb_wa_i = 5'd9;
    m_valid_i = 1; m_wa_i = 5'd9; m_wd_i = 32'h99;
    settle(); tick();
    idle_inputs();
    id_rs2_re_i = 1; id_rs2_ra_i = 5'd9;
    settle();
    chk("collision_stall", 32'(stall_o), 32'd1);
    tick();
    idle_inputs();

    // x0 handling
    p_we_i = 1; p_wa_i = 5'd0; p_wd_i = 32'hAAAA;
    m_valid_i = 1; m_wa_i = 5'd12; m_wd_i = 32'h55;
    sb_set_i = 1; sb_wa_i = 5'd0;
    settle();
    chk("x0p_m_granted", 32'(rd_wa_o), 32'd12);
    chk("x0p_ready", 32'(m_ready_o), 32'd1);
    tick();
    idle_inputs();
    m_valid_i = 1; m_wa_i = 5'd0; m_wd_i = 32'h66;
    settle();
    chk("x0m_ready", 32'(m_ready_o), 32'd1);
    chk("x0m_we", 32'(rd_we_o), 32'd0);
    tick();
    idle_inputs();

    // Randomized traffic with a well-behaved M producer and held-P re-presentation
    p_held = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_valid_i || e_gm) begin
        m_valid_i = ($urandom_range(0, 2) != 0);
        m_wa_i = AW'($urandom_range(0, 9));
        m_wd_i = $urandom;
      end
      if (!p_held) begin
        p_we_i = ($urandom_range(0, 9) < 7);
        p_wa_i = AW'($urandom_range(0, 9));
        p_wd_i = $urandom;
      end
      sb_set_i = ($urandom_range(0, 3) == 0);
      sb_wa_i = AW'($urandom_range(0, 9));
      id_rs1_re_i = $urandom_range(0, 1) != 0;
      id_rs2_re_i = $urandom_range(0, 1) != 0;
      id_we_i = $urandom_range(0, 1) != 0;
      id_rs1_ra_i = AW'($urandom_range(0, 9));
      id_rs2_ra_i = AW'($urandom_range(0, 9));
      id_wa_i = AW'($urandom_range(0, 9));
      settle();
      tick();
      p_held = e_hold && p_we_i;
    end
    idle_inputs();
    settle(); tick();

    // Asynchronous reset in the middle of WAIT
    sb_set_i = 1; sb_wa_i = 5'd20;
    settle(); tick();
    sb_set_i = 0;
    m_valid_i = 1; m_wa_i = 5'd6; m_wd_i = 32'hCAFE;
    p_we_i = 1; p_wa_i = 5'd3; p_wd_i = 32'h333;
    id_rs1_re_i = 1; id_rs1_ra_i = 5'd20;
    settle(); tick();
    settle(); tick();
    #2 rst_i = 1;
    #1;
    chk("rst_ready", 32'(m_ready_o), 32'd0);
    chk("rst_hold",  32'(p_hold_o),  32'd0);
    chk("rst_stall", 32'(stall_o),   32'd0);
    chk("rst_we",    32'(rd_we_o),   32'd0);
    chk("rst_wa",    32'(rd_wa_o),   32'd0);
    chk("rst_wd",    rd_wd_o,        32'd0);
    tick();
    settle(); tick();
    rst_i = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (k == 0) chk("post_rst_pend_clear", 32'(stall_o), 32'd0);
      if (k == 3) chk("post_rst_no_early_force", 32'(p_hold_o), 32'd0);
      if (k == 4) chk("post_rst_force", 32'(p_hold_o), 32'd1);
      tick();
      if (e_gm) m_valid_i = 0;
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
